// File: rtl/timer_interrupt_controller.sv
// timer_interrupt_controller: arbitrates pending Timer0/1/2 interrupts and runs the CPU request/ack/clear handshake
//   sysClock          in   system clock, rising edge
//   rst_n             in   synchronous active-low reset
//   TIFR_in/TIMSK_in  in   live timer flag and mask registers
//   sreg_i            in   global interrupt enable
//   irq_ack           in   CPU accepts the request
//   reti_done         in   CPU finished RETI
//   irq_request       out  interrupt request to the CPU
//   irq_vector        out  vector word address, valid with irq_request
//   TIFR_write_enable out  strobe clearing the serviced flag
//   TIFR_data         out  TIFR value written with the strobe
//   in_service        out  high from ack until reti_done
module timer_interrupt_controller #(
    parameter int                    ADDR_WIDTH     = 16,
    parameter logic [ADDR_WIDTH-1:0] VECTOR_BASE    = 16'h0008,
    parameter int                    VECTOR_STRIDE  = 2,
    parameter int                    HOLDOFF_CYCLES = 1
) (
    input  logic                  sysClock,
    input  logic                  rst_n,
    input  logic [7:0]            TIFR_in,
    input  logic [7:0]            TIMSK_in,
    input  logic                  sreg_i,
    input  logic                  irq_ack,
    input  logic                  reti_done,
    output logic                  irq_request,
    output logic [ADDR_WIDTH-1:0] irq_vector,
    output logic                  TIFR_write_enable,
    output logic [7:0]            TIFR_data,
    output logic                  in_service
);
    typedef enum logic [2:0] {IDLE, REQUEST, CLEAR, SERVICE, HOLDOFF} state_t;
    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] vector_q, vector_d;
    logic [7:0]            tifr_data_q, tifr_data_d;
    logic [3:0]            hold_cnt_q, hold_cnt_d;
    logic [7:0]            pending;
    logic [2:0]            win_idx;
    logic [ADDR_WIDTH-1:0] win_vector;
    logic [7:0]            clear_value;
    logic                  arb, hold_done;
    assign pending     = TIFR_in & TIMSK_in;
    assign arb         = sreg_i & |pending;
    assign hold_done   = hold_cnt_q == 4'(HOLDOFF_CYCLES - 1);
    assign clear_value = TIFR_in & ~(8'd1 << idx_q);
    assign win_vector  = VECTOR_BASE + ADDR_WIDTH'(VECTOR_STRIDE * (7 - int'(win_idx)));
    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        win_idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (pending[i]) win_idx = 3'(i);
    end
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vector_d    = vector_q;
        tifr_data_d = tifr_data_q;
        hold_cnt_d  = 4'd0;
        case (state_q)
            // The last holdoff cycle arbitrates like IDLE so the request lands exactly HOLDOFF_CYCLES+1 after reti_done.
            IDLE, HOLDOFF: begin
                if (state_q == HOLDOFF && !hold_done) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end else if (arb) begin
                    state_d  = REQUEST;
                    idx_d    = win_idx;
                    vector_d = win_vector;
                end else begin
                    state_d = IDLE;
                end
            end
            REQUEST: state_d = irq_ack ? CLEAR : (!sreg_i || !pending[idx_q]) ? IDLE : REQUEST;
            CLEAR: begin
                state_d     = SERVICE;
                tifr_data_d = clear_value;
            end
            SERVICE: state_d = reti_done ? HOLDOFF : SERVICE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge sysClock) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            vector_q    <= '0;
            tifr_data_q <= 8'd0;
            hold_cnt_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vector_q    <= vector_d;
            tifr_data_q <= tifr_data_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end
    // Gating with rst_n keeps a reset that lands on the CLEAR cycle from writing TIFR.
    assign TIFR_write_enable = state_q == CLEAR && rst_n;
    assign TIFR_data         = TIFR_write_enable ? clear_value : tifr_data_q;
    assign irq_request       = state_q == REQUEST;
    assign irq_vector        = vector_q;
    assign in_service        = state_q == CLEAR || state_q == SERVICE;
endmodule

// File: tb/tb_timer_interrupt_controller.sv
// tb_timer_interrupt_controller: directed bench with a behavioural model checked every cycle
module tb_timer_interrupt_controller;
    localparam int HOLD = 3;
    logic        sysClock = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  tifr = 8'h00, timsk = 8'h00;
    logic        sreg = 1'b0, ack = 1'b0, reti = 1'b0;
    logic        irq_request, tifr_we, in_service;
    logic [15:0] irq_vector;
    logic [7:0]  tifr_data;
    int          n_chk = 0, n_fail = 0;
    bit          m_req = 0, m_clr = 0, m_srv = 0;
    int          m_hold = 0;
    logic [2:0]  m_idx = 3'd0;
    logic [15:0] m_vec = 16'h0;
    logic [7:0]  m_data = 8'h0;

    timer_interrupt_controller #(.HOLDOFF_CYCLES(HOLD)) dut (
        .sysClock(sysClock), .rst_n(rst_n), .TIFR_in(tifr), .TIMSK_in(timsk),
        .sreg_i(sreg), .irq_ack(ack), .reti_done(reti),
        .irq_request(irq_request), .irq_vector(irq_vector),
        .TIFR_write_enable(tifr_we), .TIFR_data(tifr_data), .in_service(in_service)
    );

    always #5 sysClock = ~sysClock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int top_bit(input logic [7:0] p);
        for (int i = 7; i >= 0; i--) if (p[i]) return i;
        return 0;
    endfunction

    function automatic logic [15:0] vec_of(input int i);
        return 16'h0008 + 16'(2 * (7 - i));
    endfunction

    // Model: one pending event at a time -- a raised request, a clear cycle, service until RETI, then a holdoff wait.
    initial forever begin
        @(posedge sysClock);
        if (!rst_n) begin
            m_req = 0; m_clr = 0; m_srv = 0; m_hold = 0; m_idx = 0; m_vec = 0; m_data = 0;
        end else if (m_clr) begin
            m_data = tifr & ~(8'd1 << m_idx);
            m_clr = 0; m_srv = 1;
        end else if (m_srv) begin
            if (reti) begin m_srv = 0; m_hold = HOLD; end
        end else if (m_req) begin
            if (ack) begin m_req = 0; m_clr = 1; end
            else if (!sreg || !(tifr[m_idx] && timsk[m_idx])) m_req = 0;
        end else if (m_hold > 1) begin
            m_hold--;
        end else begin
            m_hold = 0;
            if (sreg && (tifr & timsk) != 0) begin
                m_req = 1;
                m_idx = 3'(top_bit(tifr & timsk));
                m_vec = vec_of(top_bit(tifr & timsk));
            end
        end
    end

    initial forever begin
        @(negedge sysClock);
        chk("irq_request", 32'(irq_request), 32'(m_req));
        if (m_req) chk("irq_vector", 32'(irq_vector), 32'(m_vec));
        chk("write_enable", 32'(tifr_we), 32'(m_clr && rst_n));
        chk("tifr_data", 32'(tifr_data), 32'((m_clr && rst_n) ? (tifr & ~(8'd1 << m_idx)) : m_data));
        chk("in_service", 32'(in_service), 32'(m_clr || m_srv));
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge sysClock); #2; end
    endtask

    task automatic finish_service();
        step(); reti = 1;
        step(); reti = 0;
        step(HOLD);
    endtask

    initial begin
        step();
        chk("rst_req", 32'(irq_request), 0);
        chk("rst_vec", 32'(irq_vector), 0);
        chk("rst_we", 32'(tifr_we), 0);
        chk("rst_data", 32'(tifr_data), 0);
        chk("rst_insvc", 32'(in_service), 0);
        rst_n = 1; tifr = 8'h01; timsk = 8'h01; sreg = 1;
        step();
        chk("t1_req", 32'(irq_request), 1);
        chk("t1_vec", 32'(irq_vector), 32'h0016);
        ack = 1;
        step(); ack = 0;
        chk("t1_we", 32'(tifr_we), 1);
        chk("t1_data", 32'(tifr_data), 32'h00);
        chk("t1_insvc", 32'(in_service), 1);
        tifr = 8'h00;
        finish_service();
        tifr = 8'h83; timsk = 8'hFF;
        step();
        chk("t2_vec", 32'(irq_vector), 32'h0008);
        ack = 1;
        step(); ack = 0;
        chk("t2_data", 32'(tifr_data), 32'h03);
        tifr = 8'h03;
        step(); reti = 1;
        step(); reti = 0;
        chk("t5_hold1", 32'(irq_request), 0);
        step(); chk("t5_hold2", 32'(irq_request), 0);
        step(); chk("t5_hold3", 32'(irq_request), 0);
        step();
        chk("t5_req", 32'(irq_request), 1);
        chk("t2_vec2", 32'(irq_vector), 32'h0014);
        ack = 1;
        step(); ack = 0;
        chk("t2_data2", 32'(tifr_data), 32'h01);
        tifr = 8'h01;
        finish_service();
        chk("t2_vec3", 32'(irq_vector), 32'h0016);
        ack = 1;
        step(); ack = 0;
        tifr = 8'h00;
        finish_service();
        tifr = 8'h04;
        step();
        chk("t3_vec", 32'(irq_vector), 32'h0012);
        sreg = 0;
        step();
        chk("t3_withdraw", 32'(irq_request), 0);
        chk("t3_nowrite", 32'(tifr_we), 0);
        step();
        chk("t3_idle", 32'(irq_request), 0);
        sreg = 1;
        step();
        chk("t3_rereq", 32'(irq_request), 1);
        ack = 1; timsk = 8'h00;
        step(); ack = 0;
        chk("t4_we", 32'(tifr_we), 1);
        chk("t4_insvc", 32'(in_service), 1);
        chk("t4_data", 32'(tifr_data), 32'h00);
        timsk = 8'hFF; tifr = 8'h00;
        finish_service();
        tifr = 8'h01;
        step();
        chk("t6_req", 32'(irq_request), 1);
        rst_n = 0;
        step();
        chk("t6_rst_req", 32'(irq_request), 0);
        chk("t6_rst_vec", 32'(irq_vector), 0);
        chk("t6_rst_we", 32'(tifr_we), 0);
        rst_n = 1;
        step();
        chk("t6_req2", 32'(irq_request), 1);
        ack = 1;
        step(); ack = 0; rst_n = 0;
        #1 chk("t6_clr_we", 32'(tifr_we), 0);
        step();
        chk("t6_clr_insvc", 32'(in_service), 0);
        chk("t6_clr_data", 32'(tifr_data), 0);
        rst_n = 1; tifr = 8'h00;
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
